// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the backing-memory responder.
// Contents: FSM state enum, LFSR seed/taps for the optional random-latency
// mode (MEM_RAND_LATENCY_EN), and the latency counter sizing.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam int unsigned MAX_LATENCY = 15;
  // Counter must also cover the up-to-3 extra cycles of the random-latency mode.
  localparam int unsigned CNT_W = $clog2(MAX_LATENCY + 4);

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bit mask over lfsr[7:0].
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mem_resp_store.sv
// Storage array for mem_responder: one synchronous read port, one write port.
// A same-edge read and write of one entry returns the old word.
// Array contents are not reset; only the read data register is.
// Ports:
//   clk, rst          clock, async active-high reset (read register only)
//   rd_en, rd_idx     load rd_data from storage[rd_idx] on this edge
//   rd_data           registered read word, holds between loads
//   wr_en, wr_idx,
//   wr_data           write storage[wr_idx] = wr_data on this edge
module mem_resp_store
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [DATA_W-1:0]     wr_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Non-blocking semantics give read-before-write on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Backing-memory responder for the cache refill interface.
// Word-addressed 64-bit storage with a fixed read latency (LATENCY cycles from
// request capture to the one-cycle mem_data_valid pulse) plus a preload port.
// Optional macro MEM_RAND_LATENCY_EN adds 0..3 extra cycles per request from
// an 8-bit LFSR that advances once per accepted request.
// Ports:
//   clk, rst         clock, async active-high reset
//   mem_rd_en        refill request, held high until the response is consumed
//   mem_addr         byte address, sampled at capture
//   mem_data         response word, held until the next response
//   mem_data_valid   one-cycle response pulse
//   busy             high in WAIT, RESP and HOLD
//   ld_en, ld_addr,
//   ld_data          preload write port, usable in any state
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_en,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_data_valid,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] ld_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [CNT_W-1:0]      eff_lat;
  logic                  accept;
  logic                  rd_load;
  logic                  unused_addr_bits;

  assign req_idx = mem_addr[DEPTH_LOG2+2:3];
  assign ld_idx  = ld_addr[DEPTH_LOG2+2:3];
  assign unused_addr_bits = ^{mem_addr[ADDR_W-1:DEPTH_LOG2+3], mem_addr[2:0],
                              ld_addr[ADDR_W-1:DEPTH_LOG2+3], ld_addr[2:0]};

  assign accept = (state == IDLE) && mem_rd_en;

`ifdef MEM_RAND_LATENCY_EN
  logic [7:0] lfsr;

  // The current LFSR value sets this request's extra latency, then it advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign eff_lat = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
  assign eff_lat = CNT_W'(LATENCY);
`endif

  // mem_data is loaded only on the edge that enters RESP. With a one-cycle
  // latency that is the capture edge, so the live request address is used.
  assign rd_load = (accept && (eff_lat == CNT_W'(1))) ||
                   ((state == WAIT) && mem_rd_en && (cnt == CNT_W'(1)));
  assign rd_idx  = (state == IDLE) ? req_idx : cap_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      cap_idx        <= '0;
      mem_data_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      mem_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_rd_en) begin
            cap_idx <= req_idx;
            cnt     <= eff_lat - CNT_W'(1);
            busy    <= 1'b1;
            if (eff_lat == CNT_W'(1)) begin
              state          <= RESP;
              mem_data_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!mem_rd_en) begin
            // Cache withdrew the request: abort without a response.
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state          <= RESP;
              mem_data_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!mem_rd_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_resp_store #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_load),
    .rd_idx  (rd_idx),
    .rd_data (mem_data),
    .wr_en   (ld_en),
    .wr_idx  (ld_idx),
    .wr_data (ld_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=4 and one LATENCY=1 instance
// share the preload bus and address; each has its own request strobe.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [63:0] ld_data;

  logic        d4_rd, d4_valid, d4_busy;
  logic [63:0] d4_data;
  logic        d1_rd, d1_valid, d1_busy;
  logic [63:0] d1_data;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] W_DEAD = 64'hDEAD_BEEF_0000_0001;

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(4), .ADDR_W(32), .DATA_W(64)) u_d4 (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_en      (d4_rd),
    .mem_addr       (mem_addr),
    .mem_data       (d4_data),
    .mem_data_valid (d4_valid),
    .busy           (d4_busy),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data)
  );

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .ADDR_W(32), .DATA_W(64)) u_d1 (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_en      (d1_rd),
    .mem_addr       (mem_addr),
    .mem_data       (d1_data),
    .mem_data_valid (d1_valid),
    .busy           (d1_busy),
    .ld_en          (ld_en),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_RAND_LATENCY_EN
  logic [7:0] lfsr_m [2];
`endif

  // Expected latency of the next accepted request on instance sel (1 = d1).
  function automatic int exp_lat(input int base, input bit sel);
`ifdef MEM_RAND_LATENCY_EN
    int e;
    e = base + int'(lfsr_m[sel][1:0]);
    lfsr_m[sel] = {lfsr_m[sel][6:0],
                   lfsr_m[sel][7] ^ lfsr_m[sel][5] ^ lfsr_m[sel][4] ^ lfsr_m[sel][3]};
    return e;
`else
    return base;
`endif
  endfunction

  task automatic model_reset();
`ifdef MEM_RAND_LATENCY_EN
    lfsr_m[0] = 8'hA5;
    lfsr_m[1] = 8'hA5;
`endif
  endtask

  function automatic logic vld(input bit sel);
    return sel ? d1_valid : d4_valid;
  endfunction

  function automatic logic bsy(input bit sel);
    return sel ? d1_busy : d4_busy;
  endfunction

  function automatic logic [63:0] dat(input bit sel);
    return sel ? d1_data : d4_data;
  endfunction

  task automatic set_rd(input bit sel, input logic v);
    if (sel) d1_rd = v;
    else d4_rd = v;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; ends at a falling edge.
  task automatic preload(input logic [31:0] a, input logic [63:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Full read: measure latency, check data, hold rd_en for `hold` cycles after
  // the pulse, then drop it for one cycle.
  task automatic req(input bit sel, input logic [31:0] a, input int base,
                     input logic [63:0] d, input int hold, input string tag);
    int lat;
    int el;
    el  = exp_lat(base, sel);
    lat = 0;
    set_rd(sel, 1'b1);
    mem_addr = a;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (vld(sel)) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(el));
    check({tag, " data"}, dat(sel), d);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, " single pulse"}, 64'(vld(sel)), 64'(0));
      check({tag, " hold data"}, dat(sel), d);
    end
    set_rd(sel, 1'b0);
    @(negedge clk);
    check({tag, " idle busy"}, 64'(bsy(sel)), 64'(0));
    check({tag, " data kept"}, dat(sel), d);
  endtask

  initial begin
    int el;
    logic        seen;
    logic [31:0] t_addr [8];
    logic [63:0] t_data [8];

    rst      = 1'b1;
    d4_rd    = 1'b0;
    d1_rd    = 1'b0;
    mem_addr = '0;
    ld_en    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset data", d4_data, 64'h0);
    check("reset valid", 64'(d4_valid), 64'(0));
    check("reset busy", 64'(d4_busy), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    preload(32'h28, W_DEAD);
    preload(32'h0, 64'h1);
    preload(32'h8, 64'h2);

    // Basic LATENCY=4 read, data held across HOLD
    req(1'b0, 32'h28, 4, W_DEAD, 2, "lat4 read");

    // LATENCY=1: held request gives one pulse; one low cycle then a new request
    req(1'b1, 32'h0, 1, 64'h1, 3, "lat1 first");
    req(1'b1, 32'h8, 1, 64'h2, 1, "lat1 second");

    // Abort in the second WAIT cycle
    void'(exp_lat(4, 1'b0));
    d4_rd    = 1'b1;
    mem_addr = 32'h38;
    @(negedge clk);
    check("abort busy in wait", 64'(d4_busy), 64'(1));
    @(negedge clk);
    check("abort no valid", 64'(d4_valid), 64'(0));
    d4_rd = 1'b0;
    @(negedge clk);
    check("abort busy drops", 64'(d4_busy), 64'(0));
    check("abort still no valid", 64'(d4_valid), 64'(0));
    req(1'b0, 32'h28, 4, W_DEAD, 1, "after abort");

    // Preload collisions: new word during WAIT, old word on the loading edge
    preload(32'h38, 64'h11);
    el       = exp_lat(4, 1'b0);
    d4_rd    = 1'b1;
    mem_addr = 32'h38;
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = 32'h38;
    ld_data = 64'hAA;
    @(negedge clk);
    ld_en = 1'b0;
    repeat (el - 3) @(negedge clk);
    ld_en   = 1'b1;
    ld_data = 64'hBB;
    @(negedge clk);
    ld_en = 1'b0;
    check("collision valid", 64'(d4_valid), 64'(1));
    check("collision read-before-write", d4_data, 64'hAA);
    @(negedge clk);
    d4_rd = 1'b0;
    @(negedge clk);
    req(1'b0, 32'h38, 4, 64'hBB, 1, "post collision");

    // Reset in the middle of WAIT
    void'(exp_lat(4, 1'b0));
    d4_rd    = 1'b1;
    mem_addr = 32'h28;
    @(negedge clk);
    #2;
    rst   = 1'b1;
    d4_rd = 1'b0;
    #1;
    check("async reset data", d4_data, 64'h0);
    check("async reset valid", 64'(d4_valid), 64'(0));
    check("async reset busy", 64'(d4_busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (d4_valid) seen = 1'b1;
    end
    check("no valid after reset", 64'(seen), 64'(0));
    req(1'b0, 32'h28, 4, W_DEAD, 1, "storage survives reset");

    // Back-to-back requests, ignored low bits and aliasing upper bits
    t_addr = '{32'h28, 32'h2D, 32'h2028, 32'h38, 32'h0, 32'h8, 32'h3F, 32'h7};
    t_data = '{W_DEAD, W_DEAD, W_DEAD, 64'hBB, 64'h1, 64'h2, 64'hBB, 64'h1};
    for (int i = 0; i < 8; i++) begin
      req(1'b0, t_addr[i], 4, t_data[i], 1, $sformatf("b2b %0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
